// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the CPU load/store bus: turns one byte-addressed
// request at a time into a word-wide SRAM access with byte enables.
module cpu_bus_responder #(
  parameter int MEM_AW     = 24,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic [25:0]       address,
  input  logic [1:0]        wlen,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RWAIT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY - 1);

  logic [1:0]        r_state;
  logic [1:0]        r_off;
  logic              r_isRead;
  logic              r_err;
  logic [1:0]        r_cnt;
  logic [31:0]       r_rdata;
  logic              r_busy;
  logic              r_done;
  logic              r_errOut;
  logic [MEM_AW-1:0] r_memAddr;
  logic              r_memEn;
  logic              r_memWe;
  logic [3:0]        r_memBe;
  logic [31:0]       r_memWdata;

  logic [1:0]        w_off;
  logic              w_isRead;
  logic              w_rangeErr;
  logic              w_alignErr;
  logic              w_err;
  logic [3:0]        w_be;
  logic [MEM_AW-1:0] w_wordAddr;
  logic [31:0]       w_laneData;
  logic [31:0]       w_rdAligned;

  assign w_off       = address[1:0];
  assign w_isRead    = (wlen == 2'b00);
  assign w_wordAddr  = address[MEM_AW+1:2];
  // Shifting out the word-address bits leaves only the must-be-zero bits; at MEM_AW=24 nothing remains.
  assign w_rangeErr  = (address >> (MEM_AW + 2)) != 26'd0;
  assign w_alignErr  = ((wlen == 2'b10) && (w_off == 2'd3)) ||
                       ((wlen == 2'b11) && (w_off != 2'd0));
  assign w_err       = w_rangeErr || w_alignErr;
  assign w_laneData  = wdata << {w_off, 3'b000};
  assign w_rdAligned = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_be = 4'b1111;
    case (wlen)
      2'b01:   w_be = 4'b0001 << w_off;
      2'b10:   w_be = 4'b0011 << w_off;
      default: w_be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state    <= S_IDLE;
      r_off      <= 2'd0;
      r_isRead   <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= 2'd0;
      r_rdata    <= 32'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_errOut   <= 1'b0;
      r_memAddr  <= '0;
      r_memEn    <= 1'b0;
      r_memWe    <= 1'b0;
      r_memBe    <= 4'd0;
      r_memWdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done   <= 1'b0;
          r_errOut <= 1'b0;
          if (start) begin
            r_off      <= w_off;
            r_isRead   <= w_isRead;
            r_err      <= w_err;
            r_busy     <= 1'b1;
            r_memAddr  <= w_wordAddr;
            r_memEn    <= !w_err;
            r_memWe    <= !w_err && !w_isRead;
            r_memBe    <= w_be;
            r_memWdata <= w_isRead ? 32'd0 : w_laneData;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_memEn <= 1'b0;
          r_memWe <= 1'b0;
          if (r_err) begin
            if (r_isRead) r_rdata <= 32'd0;
            r_done   <= 1'b1;
            r_errOut <= 1'b1;
            r_state  <= S_DONE;
          end else if (r_isRead) begin
            r_cnt   <= LAT_INIT;
            r_state <= S_RWAIT;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_RWAIT: begin
          if (r_cnt == 2'd0) begin
            r_rdata <= w_rdAligned;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: begin
          r_done   <= 1'b0;
          r_errOut <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes are gated by the reset so an aborted ISSUE never reaches the SRAM.
  assign mem_en    = r_memEn && clr_n;
  assign mem_we    = r_memWe && clr_n;
  assign mem_addr  = r_memAddr;
  assign mem_be    = r_memBe;
  assign mem_wdata = r_memWdata;
  assign rdata     = r_rdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_errOut;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Randomized bench for cpu_bus_responder with a byte-level SRAM and request model.
module tb_cpu_bus_responder;
  localparam int MEM_AW = 10;
  localparam int RD_LAT = 3;
  localparam int NWORDS = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              clr_n = 1'b0;
  logic              start = 1'b0;
  logic [25:0]       address = '0;
  logic [1:0]        wlen = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata;
  logic              busy, done, err;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_en, mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int          checks = 0;
  int          failures = 0;
  logic        preload = 1'b0;
  logic [31:0] sram [NWORDS];
  logic [31:0] rdPipe [RD_LAT];
  logic [31:0] refMem [NWORDS];
  logic [31:0] refRdata = 32'd0;

  cpu_bus_responder #(.MEM_AW(MEM_AW), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .address(address), .wlen(wlen),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Fixed-latency SRAM; garbage is returned whenever no read is in flight.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NWORDS; i++) sram[i] <= 32'd0;
      sram[1] <= 32'hAABBCCDD;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    rdPipe[0] <= (mem_en && !mem_we) ? sram[mem_addr] : $urandom;
    for (int s = 1; s < RD_LAT; s++) rdPipe[s] <= rdPipe[s-1];
  end
  assign mem_rdata = rdPipe[RD_LAT-1];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: drive in an idle cycle, then check issue, latency and result.
  task automatic applyStimulus(input logic [25:0] addr, input logic [1:0] code, input logic [31:0] data);
    int off, nb, lat, expLat;
    bit isRead, isErr;
    logic [3:0]  expBe;
    logic [31:0] expLane, laneMask, word, expRd;
    off    = int'(addr % 4);
    isRead = (code == 2'b00);
    nb     = (code == 2'b01) ? 1 : (code == 2'b10) ? 2 : 4;
    isErr  = (addr >= 26'(1 << (MEM_AW + 2))) || (!isRead && (off + nb > 4));
    expBe = 4'b0000; expLane = 32'd0; laneMask = 32'd0;
    if (isRead) expBe = 4'b1111;
    else
      for (int n = 0; n < nb && off + n < 4; n++) begin
        expBe[off+n] = 1'b1;
        expLane[8*(off+n) +: 8] = data[8*n +: 8];
        laneMask[8*(off+n) +: 8] = 8'hFF;
      end
    address = addr; wlen = code; wdata = data; start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("issue_en", 32'(mem_en), 32'(!isErr));
    checkOutput("issue_busy", 32'(busy), 32'd1);
    checkOutput("issue_done", 32'(done), 32'd0);
    if (!isErr) begin
      checkOutput("issue_we", 32'(mem_we), 32'(!isRead));
      checkOutput("issue_addr", 32'(mem_addr), 32'(addr / 4));
      checkOutput("issue_be", 32'(mem_be), 32'(expBe));
      if (!isRead) checkOutput("issue_wdata", mem_wdata & laneMask, expLane);
    end
    expLat = (isRead && !isErr) ? 2 + RD_LAT : 2;
    lat = 1;
    for (int k = 2; k <= expLat + 3; k++) begin
      tick();
      lat = k;
      if (done) break;
      checkOutput("wait_en", 32'(mem_en), 32'd0);
    end
    checkOutput("done_seen", 32'(done), 32'd1);
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("done_err", 32'(err), 32'(isErr));
    checkOutput("done_busy", 32'(busy), 32'd1);
    if (isRead) begin
      if (isErr) refRdata = 32'd0;
      else begin
        word = refMem[addr / 4];
        expRd = 32'd0;
        for (int n = 0; n < 4; n++)
          if (off + n < 4) expRd[8*n +: 8] = word[8*(off+n) +: 8];
        refRdata = expRd;
      end
    end else if (!isErr) begin
      for (int n = 0; n < nb; n++) refMem[addr / 4][8*(off+n) +: 8] = data[8*n +: 8];
    end
    checkOutput("rdata", rdata, refRdata);
    tick();
    checkOutput("after_done", 32'(done), 32'd0);
    checkOutput("after_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) refMem[i] = 32'd0;
    refMem[1] = 32'hAABBCCDD;

    // Reset held for two cycles with start asserted.
    clr_n = 1'b0; start = 1'b1; preload = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      preload = 1'b0;
      checkOutput("rst_en", 32'(mem_en), 32'd0);
      checkOutput("rst_we", 32'(mem_we), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_rdata", rdata, 32'd0);
      checkOutput("rst_be", 32'(mem_be), 32'd0);
      checkOutput("rst_addr", 32'(mem_addr), 32'd0);
      checkOutput("rst_wdata", mem_wdata, 32'd0);
    end
    start = 1'b0; clr_n = 1'b1;
    tick();

    applyStimulus(26'h0, 2'b00, 32'h0);
    applyStimulus(26'h5, 2'b00, 32'h0);
    applyStimulus(26'h4, 2'b00, 32'h0);
    applyStimulus(26'hB, 2'b01, 32'h00000012);
    applyStimulus(26'h8, 2'b10, 32'h00003456);
    applyStimulus(26'h8, 2'b00, 32'h0);
    applyStimulus(26'h6, 2'b11, 32'h11223344);
    applyStimulus(26'h7, 2'b10, 32'h00005566);
    applyStimulus(26'h8, 2'b00, 32'h0);
    applyStimulus(26'h1000, 2'b00, 32'h0);
    applyStimulus(26'h1004, 2'b11, 32'h77777777);

    // Start held high: one write accepted every third cycle.
    address = 26'h10; wlen = 2'b11; wdata = 32'hCAFEF00D; start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checkOutput("b2b_en", 32'(mem_en), 32'(k % 3 == 1));
      checkOutput("b2b_done", 32'(done), 32'(k % 3 == 2));
      if (k == 9) start = 1'b0;
    end
    refMem[4] = 32'hCAFEF00D;
    tick();
    checkOutput("b2b_stop", 32'(mem_en), 32'd0);

    // Reset during a read wait: no completion, rdata cleared.
    address = 26'h4; wlen = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    refRdata = 32'd0;
    checkOutput("rabort_busy", 32'(busy), 32'd0);
    checkOutput("rabort_rdata", rdata, 32'd0);
    for (int c = 0; c < 6; c++) begin
      checkOutput("rabort_nodone", 32'(done), 32'd0);
      tick();
    end
    applyStimulus(26'h4, 2'b00, 32'h0);

    // Reset during a write issue: the strobe drops at once and memory is untouched.
    address = 26'h20; wlen = 2'b11; wdata = 32'hDEADBEEF; start = 1'b1;
    tick();
    start = 1'b0; clr_n = 1'b0;
    #1;
    checkOutput("wabort_en", 32'(mem_en), 32'd0);
    tick();
    clr_n = 1'b1;
    refRdata = 32'd0;
    checkOutput("wabort_done", 32'(done), 32'd0);
    checkOutput("wabort_busy", 32'(busy), 32'd0);
    tick();
    applyStimulus(26'h20, 2'b00, 32'h0);

    for (int t = 0; t < 60; t++) begin
      logic [25:0] a;
      if ($urandom_range(0, 7) == 0) a = 26'h1000 + 26'($urandom_range(0, 255));
      else a = 26'($urandom_range(0, 63));
      applyStimulus(a, 2'($urandom_range(0, 3)), $urandom);
    end

    for (int i = 0; i < 24; i++) checkOutput("mem_word", sram[i], refMem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
